// File: rtl/mdu_pkg.sv
// Shared multiplier/divider definitions: operation encoding, Booth
// partial-product geometry and the Booth digit select bundle.
package mdu_pkg;

  // Encoding 2'd3 is reserved and behaves as MUL_LO.
  typedef enum logic [1:0] {
    MUL_LO  = 2'd0,
    MULH_SS = 2'd1,
    MULH_UU = 2'd2
  } mul_op_t;

  localparam int PP_NUM = 17;  // radix-4 digits for a 34-bit multiplier
  localparam int PP_W   = 34;  // partial-product width (2x of 33-bit operand)
  localparam int COLS   = 64;  // product columns

  // One Booth digit: magnitude select (one/two) plus sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_sel_t;

endpackage

// File: rtl/mul_booth_pp_stage_booth_encoder.sv
// Radix-4 Booth encoder: maps a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to a digit in {-2,-1,0,+1,+2}.
module booth_encoder
  import mdu_pkg::*;
(
  input  logic [2:0] win,
  output booth_sel_t sel
);

  // Digit decode; the 111 window is zero and is encoded with neg=0 so it
  // never produces a correction bit.
  always_comb begin
    sel = '0;
    unique case (win)
      3'b000, 3'b111: sel = '0;
      3'b001, 3'b010: sel = '{neg: 1'b0, one: 1'b1, two: 1'b0};
      3'b011:         sel = '{neg: 1'b0, one: 1'b0, two: 1'b1};
      3'b100:         sel = '{neg: 1'b1, one: 1'b0, two: 1'b1};
      3'b101, 3'b110: sel = '{neg: 1'b1, one: 1'b1, two: 1'b0};
      default:        sel = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_pp_stage.sv
// Booth partial-product stage feeding the Wallace column compressors.
// Operands, op and tag are registered; Booth recoding, partial-product
// formation and the row-to-column transposition are combinational after
// the register, so col_o holds steady while the entry is stalled.
//
// Handshake: an input transfer happens when valid_i && ready_o, an output
// transfer when valid_o && ready_i; ready_o = !valid_o || ready_i, giving
// one op per cycle when downstream is always ready. flush_i clears the
// entry on the next edge regardless of valid_i/ready_i; rst overrides both.
module mul_booth_pp_stage
  import mdu_pkg::*;
#(
  parameter int TAG_W = 6,
  parameter int COLS  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [31:0]            a_i,
  input  logic [31:0]            b_i,
  input  mul_op_t                op_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [COLS-1:0][16:0]  col_o,
  output mul_op_t                op_o,
  output logic [TAG_W-1:0]       tag_o
);

  logic                  valid_q;
  logic [31:0]           a_q;
  logic [31:0]           b_q;
  mul_op_t               op_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  accept;

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;
  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign tag_o   = tag_q;

  // Stage register: valid tracks handshake/flush, data loads on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MUL_LO;
      tag_q   <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        a_q   <= a_i;
        b_q   <= b_i;
        op_q  <= op_i;
        tag_q <= tag_i;
      end
    end
  end

  // Extension to 34 bits: only MULH_UU is unsigned; MUL_LO and the
  // reserved encoding share the signed path (low word is identical).
  logic            is_signed;
  logic [PP_W-1:0] a_ext;
  logic [PP_W-1:0] b_ext;
  logic [PP_W:0]   b_win;

  assign is_signed = (op_q != MULH_UU);
  assign a_ext     = {{2{is_signed & a_q[31]}}, a_q};
  assign b_ext     = {{2{is_signed & b_q[31]}}, b_q};
  assign b_win     = {b_ext, 1'b0};  // appends the implicit b[-1] = 0

  booth_sel_t [PP_NUM-1:0]            sel;
  logic       [PP_NUM-1:0][COLS-1:0]  rows;

  // Per-digit encoder, magnitude mux, conditional inversion and placement.
  // The +1 completing each negation lands in column 2i of row i+1, a slot
  // that row i+1 leaves empty because its own data starts at column 2i+2.
  for (genvar i = 0; i < PP_NUM; i++) begin : g_pp
    logic [PP_W-1:0] pp_mag;
    logic [PP_W-1:0] pp;
    logic [COLS-1:0] row_ext;

    booth_encoder u_enc (
      .win (b_win[2*i+2 -: 3]),
      .sel (sel[i])
    );

    assign pp_mag  = sel[i].two ? {a_ext[PP_W-2:0], 1'b0}
                   : (sel[i].one ? a_ext : '0);
    assign pp      = pp_mag ^ {PP_W{sel[i].neg}};
    assign row_ext = {{(COLS-PP_W){pp[PP_W-1]}}, pp};

    if (i == 0) begin : g_first
      assign rows[i] = row_ext;
    end else begin : g_rest
      assign rows[i] = (row_ext << (2*i)) | (COLS'(sel[i-1].neg) << (2*i-2));
    end
  end

  // Transpose rows into per-column compressor inputs.
  for (genvar k = 0; k < COLS; k++) begin : g_col
    for (genvar j = 0; j < PP_NUM; j++) begin : g_row
      assign col_o[k][j] = rows[j][k];
    end
  end

endmodule

// File: tb/tb_mul_booth_pp_stage.sv
// Directed and random bench for the Booth partial-product stage.
module tb_mul_booth_pp_stage;
  import mdu_pkg::*;

  localparam int TAG_W = 6;

  logic                  clk;
  logic                  rst;
  logic                  flush_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [31:0]           a_i;
  logic [31:0]           b_i;
  mul_op_t               op_i;
  logic [TAG_W-1:0]      tag_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [63:0][16:0]     col_o;
  mul_op_t               op_o;
  logic [TAG_W-1:0]      tag_o;

  int n_checks;
  int n_fail;

  mul_booth_pp_stage #(.TAG_W(TAG_W), .COLS(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .op_i    (op_i),
    .tag_i   (tag_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .col_o   (col_o),
    .op_o    (op_o),
    .tag_o   (tag_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product of the extended operands, modulo 2^64.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input mul_op_t op);
    logic [63:0] ae;
    logic [63:0] be;
    if (op == MULH_UU) begin
      ae = {32'b0, a};
      be = {32'b0, b};
    end else begin
      ae = {{32{a[31]}}, a};
      be = {{32{b[31]}}, b};
    end
    return ae * be;
  endfunction

  // Column-weighted popcount of the DUT's column vectors.
  function automatic logic [63:0] col_sum(input logic [63:0][16:0] c);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 17; j++)
        if (c[k][j]) s = s + (64'd1 << k);
    return s;
  endfunction

  // Bits set where a row has no content: below column 2j-2, or at 2j-1.
  function automatic int stray_bits(input logic [63:0][16:0] c);
    int n;
    n = 0;
    for (int j = 1; j < 17; j++)
      for (int k = 0; k < 2*j; k++)
        if (k != 2*j-2 && c[k][j]) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input mul_op_t op, input logic [TAG_W-1:0] tag);
    valid_i = v;
    a_i     = a;
    b_i     = b;
    op_i    = op;
    tag_i   = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated op with ready_i=1: accept, check output, check drain.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input mul_op_t op, input logic [TAG_W-1:0] tag,
                         input logic [63:0] exp);
    ready_i = 1'b1;
    drive(1'b1, a, b, op, tag);
    step();
    drive(1'b0, '0, '0, MUL_LO, '0);
    check({name, "_valid"}, 64'(valid_o), 64'd1);
    check({name, "_sum"}, col_sum(col_o), exp);
    check({name, "_tag"}, 64'(tag_o), 64'(tag));
    check({name, "_op"}, 64'(op_o), 64'(op));
    step();
    check({name, "_drain"}, 64'(valid_o), 64'd0);
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic [31:0] pa;
  logic [31:0] pb;
  mul_op_t     pop;
  logic [5:0]  ptag;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    flush_i  = 1'b0;
    ready_i  = 1'b1;

    // Reset with valid_i high: nothing may be captured.
    rst = 1'b1;
    drive(1'b1, 32'h1234_5678, 32'h9abc_def0, MULH_SS, 6'd33);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, MUL_LO, '0);
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_col", 64'(col_o != '0), 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    check("rst_op", 64'(op_o), 64'(MUL_LO));

    // Directed products.
    run_one("basic", 32'd3, 32'd5, MUL_LO, 6'd1, 64'h0000_0000_0000_000F);
    run_one("ss_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULH_SS, 6'd2, 64'h0000_0000_0000_0001);
    run_one("ss_min", 32'h8000_0000, 32'h8000_0000, MULH_SS, 6'd3, 64'h4000_0000_0000_0000);
    run_one("uu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULH_UU, 6'd4, 64'hFFFF_FFFE_0000_0001);
    ready_i = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULH_UU, 6'd4);
    step();
    drive(1'b0, '0, '0, MUL_LO, '0);
    check("uu_stray", 64'(stray_bits(col_o)), 64'd0);
    step();
    run_one("lo_neg", 32'hFFFF_FFF9, 32'd7, MUL_LO, 6'd10, 64'hFFFF_FFFF_FFFF_FFCF);
    run_one("rsvd_op", 32'hFFFF_FFFF, 32'd2, mul_op_t'(2'd3), 6'd11, 64'hFFFF_FFFF_FFFF_FFFE);
    run_one("uu_min", 32'h8000_0000, 32'h8000_0000, MULH_UU, 6'd12, 64'h4000_0000_0000_0000);
    run_one("zero", 32'h0, 32'hDEAD_BEEF, MULH_SS, 6'd13, 64'h0);

    // Backpressure: tag 5 held while tag 6 waits.
    ready_i = 1'b1;
    drive(1'b1, 32'd1000, 32'hFFFF_FFFE, MULH_SS, 6'd5);
    step();
    ready_i = 1'b0;
    drive(1'b1, 32'd77, 32'd88, MULH_UU, 6'd6);
    #1;
    check("bp_ready", 64'(ready_o), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_valid", 64'(valid_o), 64'd1);
      check("bp_tag", 64'(tag_o), 64'd5);
      check("bp_sum", col_sum(col_o), 64'hFFFF_FFFF_FFFF_F830);
      check("bp_ready_hold", 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    #1;
    check("bp_rel_ready", 64'(ready_o), 64'd1);
    check("bp_rel_tag5", 64'(tag_o), 64'd5);
    step();
    drive(1'b0, '0, '0, MUL_LO, '0);
    check("bp_t6_valid", 64'(valid_o), 64'd1);
    check("bp_t6_tag", 64'(tag_o), 64'd6);
    check("bp_t6_sum", col_sum(col_o), 64'd6776);
    step();
    check("bp_drain", 64'(valid_o), 64'd0);

    // Flush with a stalled entry and a new offer in the same cycle.
    ready_i = 1'b0;
    drive(1'b1, 32'd9, 32'd9, MUL_LO, 6'd7);
    step();
    check("fl_pre_valid", 64'(valid_o), 64'd1);
    flush_i = 1'b1;
    drive(1'b1, 32'd4, 32'd4, MUL_LO, 6'd8);
    step();
    flush_i = 1'b0;
    drive(1'b0, '0, '0, MUL_LO, '0);
    check("fl_valid", 64'(valid_o), 64'd0);
    check("fl_ready", 64'(ready_o), 64'd1);
    ready_i = 1'b1;
    step();
    check("fl_quiet", 64'(valid_o), 64'd0);

    // Reset during a stall drops the entry.
    ready_i = 1'b0;
    drive(1'b1, 32'd2, 32'd2, MUL_LO, 6'd9);
    step();
    check("rs_pre_valid", 64'(valid_o), 64'd1);
    rst = 1'b1;
    drive(1'b0, '0, '0, MUL_LO, '0);
    step();
    rst = 1'b0;
    check("rs_valid", 64'(valid_o), 64'd0);
    check("rs_tag", 64'(tag_o), 64'd0);

    // Random back-to-back streams, 10k ops per op type.
    ready_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      pop = (t == 0) ? MUL_LO : ((t == 1) ? MULH_SS : MULH_UU);
      for (int n = 0; n < 10000; n++) begin
        ra = $urandom_range(32'hFFFF_FFFF, 0);
        rb = $urandom_range(32'hFFFF_FFFF, 0);
        if (n % 16 == 0) ra = {ra[31], 31'(ra[31] ? 0 : 32'h7FFF_FFFF)};
        if (n % 16 == 1) rb = {rb[31], 31'(rb[31] ? 0 : 32'h7FFF_FFFF)};
        ptag = 6'(n);
        pa = ra;
        pb = rb;
        drive(1'b1, pa, pb, pop, ptag);
        step();
        check("rnd_valid", 64'(valid_o), 64'd1);
        check("rnd_tag", 64'(tag_o), 64'(ptag));
        check("rnd_sum", col_sum(col_o), ref_prod(pa, pb, pop));
      end
    end
    drive(1'b0, '0, '0, MUL_LO, '0);
    step();
    check("rnd_drain", 64'(valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_booth_pp_stage.md
Name: mul_booth_pp_stage

Overview:
- Pipeline stage directly upstream of the 17-way Wallace tree column compressors in the MDU multiplier.
- Registers the 32x32 operands and radix-4 Booth-recodes the multiplier into 17 partial products.
- Transposes the partial products into 64 per-column 17-bit vectors. Each vector feeds one column compressor's `in[16:0]`.
- Provides a valid/ready handshake, flush and a pass-through tag so the multiplier can be pipelined and stalled.

Parameters:
- TAG_W, 6, width of the opaque tag carried alongside the operation (ROB index).
- COLS, 64, number of product columns emitted. Fixed at 64; any other value is unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  kill the held entry and any entry accepted this cycle
- valid_i  in  1  upstream operands valid
- ready_o  out  1  stage can accept
- a_i  in  32  multiplicand
- b_i  in  32  multiplier
- op_i  in  2  mul_op_t: MUL_LO, MULH_SS, MULH_UU
- tag_i  in  TAG_W  opaque tag
- valid_o  out  1  column data valid
- ready_i  in  1  downstream (Wallace stage) accepts
- col_o  out  COLS x 17  col_o[k][j] = bit k of weighted row j
- op_o  out  2  registered op
- tag_o  out  TAG_W  registered tag

Behaviour:
- Reset: valid_o=0; op_o=MUL_LO; tag_o=0; col_o all-zero; operand registers zeroed.
- Handshake:
  - ready_o = !valid_o || ready_i.
  - Transfer in when valid_i && ready_o. Transfer out when valid_o && ready_i.
- Latency: 1 cycle. Registers are operands/op/tag. Booth recoding and transposition are combinational after the register, so col_o is stable while valid_o && !ready_i.
- Back-to-back: full throughput, one op per cycle when ready_i=1.
- Flush: flush_i=1 forces valid_o=0 next cycle regardless of valid_i or ready_i. Data registers may update but are don't-care.
- Reset priority: rst overrides flush_i, which overrides the handshake. Reset mid-stall drops the entry.
- Operand extension to 34 bits:
  - Signed (MUL_LO, MULH_SS): sign-extend a and b.
  - Unsigned (MULH_UU): zero-extend a and b.
  - MUL_LO low 32 bits are identical either way.
- Booth digit d_i for i=0..16 comes from {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Digit values: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
- Partial product magnitudes:
  - pp_i = |d_i| x a_ext, as a 34-bit value.
  - If d_i < 0, pp_i is bitwise inverted and neg_i=1.
  - pp_i is sign-extended to 64 bits, shifted left by 2i, and truncated to 64 bits.
- Negation correction: neg_i is placed at column 2i of row i+1 (i=0..15). Those columns of row i+1 are otherwise zero.
- d_16 is never negative (34-bit extension), so neg_16 is never needed.
- Row 16 holds pp_16 only.
- Invariant: sum over k,j of col_o[k][j] x 2^k mod 2^64 = (a_ext x b_ext) mod 2^64.
- Downstream selects [31:0] for MUL_LO and [63:32] otherwise.
- No column exceeds 17 bits; unused bits are 0.

Decomposition:
- Shared mdu_pkg holds:
  - mul_op_t enum (MUL_LO=0, MULH_SS=1, MULH_UU=2; 3 reserved, treated as MUL_LO).
  - Constants: PP_NUM=17, PP_W=34, COLS=64.
  - booth_sel_t struct {neg, one, two}.
- One sub-module: booth_encoder, which maps a 3-bit window to booth_sel_t. It is instantiated 17 times.
- The partial-product mux and transposition are generate loops in the top.

Test Plan:
- Reset: rst high 2 cycles with valid_i=1 -> valid_o=0, col_o=0, ready_o=1 in the cycle after rst drops.
- Basic: a=3, b=5, MUL_LO -> one cycle later valid_o=1; column-weighted popcount sum = 0x0000_0000_0000_000F.
- Signed extremes:
  - a=b=0xFFFF_FFFF, MULH_SS -> sum = 0x0000_0000_0000_0001.
  - a=b=0x8000_0000, MULH_SS -> sum = 0x4000_0000_0000_0000.
- Unsigned: a=b=0xFFFF_FFFF, MULH_UU -> sum = 0xFFFF_FFFE_0000_0001. No col_o[k] has a nonzero bit above index 16 in the packed view.
- Backpressure: accept tag=5, then hold ready_i=0 for 3 cycles while offering tag=6 -> ready_o=0, col_o/tag_o stable at tag 5. Release -> tag 5 out, then tag 6 out on the next cycle.
- Flush: valid_o=1 and ready_i=0, assert flush_i with valid_i=1 -> next cycle valid_o=0, ready_o=1, and neither entry is emitted. Random 10k ops per op type must match the reference product.
